// File: rtl/br_ras.sv
// Branch-target unit with a circular return-address stack.
// Targets are registered one cycle after the request; full/empty track the post-edge count.
module br_ras #(
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          br_req,
  input  logic [2:0]    br_mode,
  input  logic [AW-1:0] pc_inc,
  input  logic [AW-1:0] imm,
  input  logic [AW-1:0] reg_tgt,
  input  logic          flush,
  output logic [AW-1:0] br_addr,
  output logic          br_valid,
  output logic          ras_full,
  output logic          ras_empty,
  output logic          ras_ovf,
  output logic          ras_unf,
  output logic          mode_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] MODE_REL  = 3'd0;
  localparam logic [2:0] MODE_ABS  = 3'd1;
  localparam logic [2:0] MODE_REG  = 3'd2;
  localparam logic [2:0] MODE_CALL = 3'd3;
  localparam logic [2:0] MODE_RET  = 3'd4;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] tp, nxt_tp;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [AW-1:0] nxt_addr;
  logic          nxt_valid, nxt_err, nxt_ovf, nxt_unf, push_en;

  assign ras_full  = (cnt == CW'(DEPTH));
  assign ras_empty = (cnt == '0);

  // Target selection and stack pointer update; flush overrides pointer state last.
  always_comb begin
    nxt_addr  = br_addr;
    nxt_valid = 1'b0;
    nxt_err   = 1'b0;
    nxt_tp    = tp;
    nxt_cnt   = cnt;
    nxt_ovf   = ras_ovf;
    nxt_unf   = ras_unf;
    push_en   = 1'b0;
    if (br_req) begin
      case (br_mode)
        MODE_REL: begin
          nxt_addr  = pc_inc + imm;
          nxt_valid = 1'b1;
        end
        MODE_ABS: begin
          nxt_addr  = imm;
          nxt_valid = 1'b1;
        end
        MODE_REG: begin
          nxt_addr  = reg_tgt;
          nxt_valid = 1'b1;
        end
        MODE_CALL: begin
          nxt_addr  = pc_inc + imm;
          nxt_valid = 1'b1;
          if (!flush) begin
            push_en = 1'b1;
            nxt_tp  = tp + PW'(1);
            if (ras_full) nxt_ovf = 1'b1;
            else          nxt_cnt = cnt + CW'(1);
          end
        end
        MODE_RET: begin
          nxt_valid = 1'b1;
          if (flush) begin
            nxt_addr = '0;
          end else if (ras_empty) begin
            nxt_addr = '0;
            nxt_unf  = 1'b1;
          end else begin
            nxt_addr = mem[tp];
            nxt_tp   = tp - PW'(1);
            nxt_cnt  = cnt - CW'(1);
          end
        end
        default: nxt_err = 1'b1;
      endcase
    end
    if (flush) begin
      nxt_tp  = '0;
      nxt_cnt = '0;
      nxt_ovf = 1'b0;
      nxt_unf = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_addr  <= '0;
      br_valid <= 1'b0;
      mode_err <= 1'b0;
      ras_ovf  <= 1'b0;
      ras_unf  <= 1'b0;
      tp       <= '0;
      cnt      <= '0;
    end else begin
      br_addr  <= nxt_addr;
      br_valid <= nxt_valid;
      mode_err <= nxt_err;
      ras_ovf  <= nxt_ovf;
      ras_unf  <= nxt_unf;
      tp       <= nxt_tp;
      cnt      <= nxt_cnt;
    end
  end

  // Stack storage needs no reset; entries are only read when count says they are live.
  always_ff @(posedge clk) begin
    if (!rst && push_en) mem[nxt_tp] <= pc_inc;
  end

endmodule

// File: tb/tb_br_ras.sv
// Scoreboard bench for br_ras: a queue-based stack model predicts every cycle's outputs.
module tb_br_ras;

  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst, br_req, flush;
  logic [2:0]    br_mode;
  logic [AW-1:0] pc_inc, imm, reg_tgt;
  logic [AW-1:0] br_addr;
  logic          br_valid, ras_full, ras_empty, ras_ovf, ras_unf, mode_err;

  br_ras #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .br_req(br_req), .br_mode(br_mode),
    .pc_inc(pc_inc), .imm(imm), .reg_tgt(reg_tgt), .flush(flush),
    .br_addr(br_addr), .br_valid(br_valid), .ras_full(ras_full),
    .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf),
    .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic valid, err, full, empty, ovf, unf;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] stk[$];
  logic [AW-1:0] m_addr = '0;
  logic          m_ovf = 1'b0, m_unf = 1'b0;
  int            n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Predict, drive one cycle, then compare the popped expectation against the DUT.
  task automatic step(input string tag, input logic r, input logic req, input logic [2:0] mode,
                      input logic [AW-1:0] pc, input logic [AW-1:0] im,
                      input logic [AW-1:0] rg, input logic fl);
    exp_t e;
    e = '0;
    if (r) begin
      m_addr = '0; m_ovf = 0; m_unf = 0; stk.delete();
    end else begin
      if (req) begin
        case (mode)
          3'd0: begin m_addr = pc + im; e.valid = 1; end
          3'd1: begin m_addr = im;      e.valid = 1; end
          3'd2: begin m_addr = rg;      e.valid = 1; end
          3'd3: begin
            m_addr = pc + im; e.valid = 1;
            if (!fl) begin
              if (stk.size() == DEPTH) begin m_ovf = 1; void'(stk.pop_front()); end
              stk.push_back(pc);
            end
          end
          3'd4: begin
            e.valid = 1;
            if (fl) m_addr = '0;
            else if (stk.size() == 0) begin m_addr = '0; m_unf = 1; end
            else m_addr = stk.pop_back();
          end
          default: e.err = 1;
        endcase
      end
      if (fl) begin stk.delete(); m_ovf = 0; m_unf = 0; end
    end
    e.addr  = m_addr;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.full  = (stk.size() == DEPTH);
    e.empty = (stk.size() == 0);
    exp_q.push_back(e);
    rst = r; br_req = req; br_mode = mode; pc_inc = pc; imm = im; reg_tgt = rg; flush = fl;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".addr"},  32'(br_addr),   32'(e.addr));
    check({tag, ".valid"}, 32'(br_valid),  32'(e.valid));
    check({tag, ".err"},   32'(mode_err),  32'(e.err));
    check({tag, ".full"},  32'(ras_full),  32'(e.full));
    check({tag, ".empty"}, 32'(ras_empty), 32'(e.empty));
    check({tag, ".ovf"},   32'(ras_ovf),   32'(e.ovf));
    check({tag, ".unf"},   32'(ras_unf),   32'(e.unf));
  endtask

  initial begin
    rst = 1; br_req = 0; br_mode = '0; pc_inc = '0; imm = '0; reg_tgt = '0; flush = 0;
    @(posedge clk); #1;
    step("rst", 1, 0, 3'd0, 16'h0, 16'h0, 16'h0, 0);
    check("rst_empty", 32'(ras_empty), 32'd1);
    check("rst_addr", 32'(br_addr), 32'd0);

    step("rel", 0, 1, 3'd0, 16'h0010, 16'h0005, 16'h0, 0);
    check("rel_const", 32'(br_addr), 32'h0015);
    step("abs", 0, 1, 3'd1, 16'h0010, 16'h1234, 16'h0, 0);
    check("abs_const", 32'(br_addr), 32'h1234);
    step("reg", 0, 1, 3'd2, 16'h0010, 16'h1234, 16'hBEEF, 0);
    check("reg_const", 32'(br_addr), 32'hBEEF);
    step("idle", 0, 0, 3'd0, 16'h5555, 16'h5555, 16'h5555, 0);
    step("wrap1", 0, 1, 3'd0, 16'hFFFE, 16'h0003, 16'h0, 0);
    check("wrap1_const", 32'(br_addr), 32'h0001);
    step("wrap2", 0, 1, 3'd0, 16'h0010, 16'hFFFF, 16'h0, 0);
    check("wrap2_const", 32'(br_addr), 32'h000F);

    for (int i = 1; i <= 3; i++) step("call3", 0, 1, 3'd3, AW'(i * 16'h0101), 16'h0020, 16'h0, 0);
    step("ret3a", 0, 1, 3'd4, 16'h0, 16'h0, 16'h0, 0);
    check("ret3a_const", 32'(br_addr), 32'h0303);
    step("ret3b", 0, 1, 3'd4, 16'h0, 16'h0, 16'h0, 0);
    step("ret3c", 0, 1, 3'd4, 16'h0, 16'h0, 16'h0, 0);
    check("ret3c_const", 32'(br_addr), 32'h0101);
    check("ret3c_empty", 32'(ras_empty), 32'd1);

    for (int i = 1; i <= DEPTH + 1; i++) step("call9", 0, 1, 3'd3, AW'(i), 16'h0100, 16'h0, 0);
    check("ovf_const", 32'(ras_ovf), 32'd1);
    check("full_const", 32'(ras_full), 32'd1);
    for (int i = 0; i < DEPTH; i++) step("ret8", 0, 1, 3'd4, 16'h0, 16'h0, 16'h0, 0);
    check("ret8_last", 32'(br_addr), 32'h0002);
    step("ret_unf", 0, 1, 3'd4, 16'h0, 16'h0, 16'h0, 0);
    check("unf_const", 32'(ras_unf), 32'd1);

    step("ill5", 0, 1, 3'd5, 16'h0, 16'h0, 16'h0, 0);
    step("ill_after", 0, 0, 3'd0, 16'h0, 16'h0, 16'h0, 0);
    step("ill7", 0, 1, 3'd7, 16'h0, 16'h0, 16'h0, 0);
    step("pre_fl", 0, 1, 3'd3, 16'h0031, 16'h0, 16'h0, 0);
    step("pre_fl", 0, 1, 3'd3, 16'h0032, 16'h0, 16'h0, 0);
    step("fl_call", 0, 1, 3'd3, 16'h0040, 16'h0004, 16'h0, 1);
    check("fl_call_const", 32'(br_addr), 32'h0044);
    step("pre_fl2", 0, 1, 3'd3, 16'h0050, 16'h0, 16'h0, 0);
    step("fl_ret", 0, 1, 3'd4, 16'h0, 16'h0, 16'h0, 1);

    step("pre_rst", 0, 1, 3'd3, 16'h0061, 16'h0, 16'h0, 0);
    step("pre_rst", 0, 1, 3'd3, 16'h0062, 16'h0, 16'h0, 0);
    step("rst_call", 1, 1, 3'd3, 16'h0063, 16'h0001, 16'h0, 0);
    step("rst_ret", 0, 1, 3'd4, 16'h0, 16'h0, 16'h0, 0);
    check("rst_ret_unf", 32'(ras_unf), 32'd1);

    for (int i = 0; i < 300; i++)
      step("rand", 0, ($urandom_range(0, 7) != 0), 3'($urandom_range(0, 5)),
           AW'($urandom), AW'($urandom), AW'($urandom), ($urandom_range(0, 31) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
